// File: rtl/bbs_pkg.sv
// rtl/bbs_pkg.sv - shared state encoding, default modulus and width helper for the BBS scheduler
package bbs_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEED,
      WARM,
      READY,
      BUSY,
      DONE
   } state_t;

   localparam int DEFAULT_M = 253;

   // Counter width helper; never returns less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/bbs_sched_if.sv
// rtl/bbs_sched_if.sv - seed, request and response signals between consumers and the BBS scheduler
interface bbs_sched_if #(
   parameter int W     = 16,
   parameter int NREQ  = 4,
   parameter int OUT_W = 8
);
   logic             seed_valid;
   logic [W-1:0]     seed;
   logic             seed_ready;
   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  gnt;
   logic [NREQ-1:0]  rsp_valid;
   logic [OUT_W-1:0] rsp_data;
   logic             seeded;
   logic             busy;

   modport master (
      output seed_valid, seed, req,
      input  seed_ready, gnt, rsp_valid, rsp_data, seeded, busy
   );

   modport slave (
      input  seed_valid, seed, req,
      output seed_ready, gnt, rsp_valid, rsp_data, seeded, busy
   );
endinterface

// File: rtl/bbs_step.sv
// rtl/bbs_step.sv - one combinational Blum Blum Shub squaring step, x -> (x*x) mod M
module bbs_step
   import bbs_pkg::*;
#(
   parameter int           W = 16,
   parameter logic [W-1:0] M = W'(DEFAULT_M)
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] x_next
);
   logic [2*W-1:0] sq;
   logic [2*W-1:0] rem;

   always_comb begin
      sq     = {{W{1'b0}}, x} * {{W{1'b0}}, x};
      rem    = sq % {{W{1'b0}}, M};
      x_next = rem[W-1:0];
   end
endmodule

// File: rtl/bbs_sched.sv
// rtl/bbs_sched.sv - round-robin scheduler sharing one BBS generator state among NREQ requesters
module bbs_sched
   import bbs_pkg::*;
#(
   parameter int           W      = 16,
   parameter logic [W-1:0] M      = W'(DEFAULT_M),
   parameter int           NREQ   = 4,
   parameter int           OUT_W  = 8,
   parameter int           WARMUP = 4
) (
   input  logic       clk,
   input  logic       reset,
   bbs_sched_if.slave bus
);
   localparam int PW = clog2(NREQ);
   localparam int CW = clog2(OUT_W + WARMUP + 1);

   state_t            state;
   logic [W-1:0]      x;
   logic [W-1:0]      x_next;
   logic [W-1:0]      x_mod;
   logic [W-1:0]      x_seed;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     owner;
   logic [PW-1:0]     pick;
   logic              pick_any;
   logic [CW-1:0]     step_cnt;
   logic [2*NREQ-1:0] req_rot;
   logic              seed_fire;
   logic              seed_ready_q;
   logic              seeded_q;
   logic              busy_q;
   logic [NREQ-1:0]   gnt_q;
   logic [NREQ-1:0]   rsp_valid_q;
   logic [OUT_W-1:0]  rsp_data_q;

   bbs_step #(.W(W), .M(M)) u_step (
      .x      (x),
      .x_next (x_next)
   );

   assign seed_fire = bus.seed_valid && seed_ready_q;
   assign x_mod     = x % M;
   // 0 and 1 are fixed points of squaring, so they would lock the stream.
   assign x_seed    = (x_mod < W'(2)) ? W'(3) : x_mod;

   // Rotate so rr_ptr lands on bit 0; the lowest set bit is the next grant.
   always_comb begin
      req_rot  = {bus.req, bus.req} >> rr_ptr;
      pick     = '0;
      pick_any = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            pick     = PW'((int'(rr_ptr) + i) % NREQ);
            pick_any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         x            <= '0;
         rr_ptr       <= '0;
         owner        <= '0;
         step_cnt     <= '0;
         seed_ready_q <= 1'b1;
         seeded_q     <= 1'b0;
         busy_q       <= 1'b0;
         gnt_q        <= '0;
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
      end else begin
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         case (state)
            IDLE, READY: begin
               if (seed_fire) begin
                  x            <= bus.seed;
                  seeded_q     <= 1'b0;
                  seed_ready_q <= 1'b0;
                  busy_q       <= 1'b1;
                  state        <= SEED;
               end else if (state == READY && pick_any) begin
                  gnt_q        <= NREQ'(1) << pick;
                  owner        <= pick;
                  rr_ptr       <= PW'((int'(pick) + 1) % NREQ);
                  step_cnt     <= '0;
                  seed_ready_q <= 1'b0;
                  busy_q       <= 1'b1;
                  state        <= BUSY;
               end
            end
            SEED: begin
               x        <= x_seed;
               step_cnt <= '0;
               if (WARMUP == 0) begin
                  seeded_q     <= 1'b1;
                  seed_ready_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state        <= READY;
               end else begin
                  state <= WARM;
               end
            end
            WARM: begin
               x <= x_next;
               if (step_cnt == CW'(WARMUP - 1)) begin
                  step_cnt     <= '0;
                  seeded_q     <= 1'b1;
                  seed_ready_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state        <= READY;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            BUSY: begin
               x <= x_next;
               for (int i = 0; i < OUT_W; i++) begin
                  if (step_cnt == CW'(i)) rsp_data_q[i] <= x_next[0];
               end
               if (step_cnt == CW'(OUT_W - 1)) begin
                  step_cnt <= '0;
                  state    <= DONE;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            DONE: begin
               rsp_valid_q  <= NREQ'(1) << owner;
               seed_ready_q <= 1'b1;
               busy_q       <= 1'b0;
               state        <= READY;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.seed_ready = seed_ready_q;
   assign bus.seeded     = seeded_q;
   assign bus.busy       = busy_q;
   assign bus.gnt        = gnt_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
endmodule

// File: tb/tb_bbs_sched.sv
// tb/tb_bbs_sched.sv - scoreboard bench driving a WARMUP=0 and a WARMUP=4 scheduler with shared stimulus
module tb_bbs_sched;
   localparam int NL    = 2;
   localparam int NREQ  = 4;
   localparam int OUT_W = 4;
   localparam int MOD   = 253;
   localparam int M_IDLE = 0, M_READY = 1, M_SEEDING = 2, M_SERVING = 3;

   logic        clk        = 1'b0;
   logic        reset      = 1'b0;
   logic        seed_valid = 1'b0;
   logic [15:0] seed       = '0;
   logic [3:0]  req        = '0;

   logic [NL-1:0]      o_seed_ready, o_seeded, o_busy;
   logic [NL-1:0][3:0] o_gnt, o_rsp_valid, o_rsp_data;

   int cyc = 0, n_cmp = 0, n_mis = 0, tmo_cnt = 0, tmo_seen = 0;

   typedef struct {
      int         lane;
      int         who;
      logic [3:0] data;
      int         due;
      int         nth;
      int         seedv;
   } exp_t;
   exp_t sbq[$];

   int         mmode[NL], mcnt[NL], mrr[NL], mnth[NL], mseedv[NL];
   longint     mx[NL];
   logic       mseeded[NL];
   logic [3:0] mgnt[NL];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NL; g++) begin : lane
      bbs_sched_if #(.W(16), .NREQ(NREQ), .OUT_W(OUT_W)) bus ();
      assign bus.seed_valid  = seed_valid;
      assign bus.seed        = seed;
      assign bus.req         = req;
      assign o_seed_ready[g] = bus.seed_ready;
      assign o_seeded[g]     = bus.seeded;
      assign o_busy[g]       = bus.busy;
      assign o_gnt[g]        = bus.gnt;
      assign o_rsp_valid[g]  = bus.rsp_valid;
      assign o_rsp_data[g]   = bus.rsp_data;
      bbs_sched #(.W(16), .M(16'd253), .NREQ(NREQ), .OUT_W(OUT_W), .WARMUP(g == 0 ? 0 : 4)) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );
   end

   function automatic int warmup_of(input int l);
      return (l == 0) ? 0 : 4;
   endfunction

   function automatic longint sq_mod(input longint v);
      return (v * v) % MOD;
   endfunction

   task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s lane%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, l, act, exp, cyc);
      end
   endtask

   // Reference model: per-lane phase with a cycle countdown, plain modular arithmetic for the stream.
   always @(negedge clk) begin
      longint     v;
      int         g;
      logic [3:0] d;
      for (int l = 0; l < NL; l++) begin
         if (!reset) begin
            mmode[l] = M_IDLE; mcnt[l] = 0; mrr[l] = 0; mnth[l] = 0; mseedv[l] = 0;
            mx[l] = 0; mseeded[l] = 1'b0; mgnt[l] = '0;
            chk("reset_seed_ready", l, o_seed_ready[l], 1);
            chk("reset_seeded", l, o_seeded[l], 0);
            chk("reset_busy", l, o_busy[l], 0);
            chk("reset_gnt", l, o_gnt[l], 0);
            chk("reset_rsp_data", l, o_rsp_data[l], 0);
         end else begin
            chk("seed_ready", l, o_seed_ready[l], (mmode[l] == M_IDLE || mmode[l] == M_READY));
            chk("busy", l, o_busy[l], (mmode[l] >= M_SEEDING));
            chk("seeded", l, o_seeded[l], mseeded[l]);
            chk("gnt", l, o_gnt[l], mgnt[l]);
            mgnt[l] = '0;
            if ((mmode[l] == M_IDLE || mmode[l] == M_READY) && seed_valid) begin
               v = longint'(seed) % MOD;
               if (v < 2) v = 3;
               for (int k = 0; k < warmup_of(l); k++) v = sq_mod(v);
               mx[l] = v; mseeded[l] = 1'b0; mnth[l] = 0; mseedv[l] = int'(seed);
               mmode[l] = M_SEEDING; mcnt[l] = 1 + warmup_of(l);
            end else if (mmode[l] == M_READY && req != 0) begin
               g = -1;
               for (int k = 0; k < NREQ; k++)
                  if (g < 0 && req[(mrr[l] + k) % NREQ]) g = (mrr[l] + k) % NREQ;
               d = '0;
               for (int b = 0; b < OUT_W; b++) begin
                  mx[l] = sq_mod(mx[l]);
                  d[b]  = mx[l][0];
               end
               sbq.push_back('{lane: l, who: g, data: d, due: cyc + OUT_W + 2, nth: mnth[l], seedv: mseedv[l]});
               mnth[l]++;
               mrr[l]   = (g + 1) % NREQ;
               mgnt[l]  = 4'(1) << g;
               mmode[l] = M_SERVING;
               mcnt[l]  = OUT_W + 1;
            end else if (mmode[l] >= M_SEEDING) begin
               mcnt[l]--;
               if (mcnt[l] == 0) begin
                  if (mmode[l] == M_SEEDING) mseeded[l] = 1'b1;
                  mmode[l] = M_READY;
               end
            end
         end
      end
   end

   // Monitor: matches every presented response with the oldest expectation for that lane.
   always @(negedge clk) begin
      int   found;
      exp_t e;
      if (tmo_cnt != tmo_seen) begin
         chk("wait_gnt_timeout", 0, tmo_cnt, tmo_seen);
         tmo_seen = tmo_cnt;
      end
      if (!reset) begin
         for (int l = 0; l < NL; l++) chk("reset_rsp_valid", l, o_rsp_valid[l], 0);
         sbq.delete();
      end else begin
         for (int l = 0; l < NL; l++) begin
            if (o_rsp_valid[l] != 0) begin
               found = -1;
               for (int i = 0; i < sbq.size(); i++)
                  if (found < 0 && sbq[i].lane == l) found = i;
               if (found < 0) begin
                  chk("rsp_unexpected", l, o_rsp_valid[l], 0);
               end else begin
                  e = sbq[found];
                  sbq.delete(found);
                  chk("rsp_cycle", l, cyc, e.due);
                  chk("rsp_valid", l, o_rsp_valid[l], 4'(1) << e.who);
                  chk("rsp_data", l, o_rsp_data[l], e.data);
                  if ((e.seedv % MOD) < 2 || (e.seedv % MOD) == 3) begin
                     if (l == 0 && e.nth == 0) chk("seed3_first_w0", l, o_rsp_data[l], 4'h3);
                     else if (l == 0 && e.nth == 1) chk("seed3_second_w0", l, o_rsp_data[l], 4'h5);
                     else if (l == 1 && e.nth == 0) chk("seed3_first_w4", l, o_rsp_data[l], 4'h5);
                  end
               end
            end
         end
         for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due < cyc) begin
               chk("rsp_missing", sbq[i].lane, 0, 1);
               sbq.delete(i);
            end
         end
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic offer(input logic [15:0] s);
      seed       = s;
      seed_valid = 1'b1;
      cyc_wait(1);
      seed_valid = 1'b0;
   endtask

   initial begin
      bit got;
      cyc_wait(3);
      reset = 1'b1;
      req = 4'hF;
      cyc_wait(10);
      req = '0;
      offer(16'd3);
      req = 4'b0001;
      cyc_wait(26);
      req = 4'b1011;
      cyc_wait(40);
      seed = 16'd3;
      seed_valid = 1'b1;
      cyc_wait(8);
      seed_valid = 1'b0;
      cyc_wait(30);
      req = '0;
      cyc_wait(8);
      offer(16'd253);
      req = 4'b0001;
      cyc_wait(16);
      req = '0;
      cyc_wait(8);
      offer(16'd1);
      req = 4'b0010;
      cyc_wait(16);
      req = '0;
      cyc_wait(8);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
         seed_valid = ($urandom_range(0, 24) == 0);
         seed = 16'($urandom);
         cyc_wait(1);
      end
      seed_valid = 1'b0;
      req = '0;
      cyc_wait(10);
      offer(16'd3);
      cyc_wait(8);
      req = 4'b0100;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         cyc_wait(1);
         got = (o_gnt[0] != 0);
      end
      if (!got) tmo_cnt++;
      @(posedge clk);
      #3;
      reset = 1'b0;
      cyc_wait(3);
      reset = 1'b1;
      cyc_wait(6);
      offer(16'd77);
      cyc_wait(30);
      req = '0;
      cyc_wait(20);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
